// File: rtl/rv32im_fetch_pkg.sv
// rv32im_fetch_pkg: definitions shared by the fetch stage and its neighbours.
//   fetch_state_e    - fetch FSM state encoding
//   ILEN/ILEN_BYTES  - instruction width in bits / bytes (sequential PC step)
//   RESET_PC_DEFAULT - default first fetch address, also used by decode/execute
package rv32im_fetch_pkg;

  localparam int unsigned ILEN       = 32;
  localparam int unsigned ILEN_BYTES = ILEN / 8;

  typedef logic [ILEN-1:0] instr_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    DISCARD = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/rv32im_fetch_if.sv
// rv32im_fetch_if: single-outstanding request/acknowledge instruction read bus.
//   mem_stb_o  - read request strobe (held with mem_addr_o until mem_ack_i)
//   mem_addr_o - word-aligned read address
//   mem_ack_i  - read complete, mem_data_i valid this cycle
//   mem_data_i - read data
// master: fetch stage side; slave: memory side.
interface rv32im_fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_stb_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_ack_i;
  logic [XLEN-1:0] mem_data_i;

  modport master (
    output mem_stb_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_data_i
  );

  modport slave (
    input  mem_stb_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_data_i
  );
endinterface

// File: rtl/rv32im_fetch_fifo.sv
// rv32im_fetch_fifo: synchronous FIFO with flush and combinational head read.
//   clk_i/rst_ni - clock, asynchronous active-low reset
//   flush_i      - empty the FIFO; overrides push/pop this cycle
//   push_i       - write wdata_i (ignored when full without a pop)
//   pop_i        - drop head entry (ignored when empty)
//   rdata_o      - head entry
//   full_o/empty_o/count_o - occupancy
// DEPTH must be a power of two so pointers wrap naturally.
module rv32im_fetch_fifo #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic                pop_i,
  output logic [WIDTH-1:0]    rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [PTR_BITS:0]   count_o
);

  localparam int unsigned CNT_W = PTR_BITS + 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rv32im_fetch.sv
// rv32im_fetch: instruction fetch stage feeding the decoder.
// Issues one read at a time on the instruction bus from a sequential PC,
// buffers {instruction, pc} in a prefetch FIFO and presents the head.
// A redirect flushes the FIFO, discards any in-flight read and restarts
// fetch at the (word-aligned) target.
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   mem                - instruction bus (rv32im_fetch_if.master)
//   stall_i            - downstream hold, nothing is presented
//   redirect_i         - flush and restart at redirect_pc_i
//   redirect_pc_i      - new fetch address, bits [1:0] ignored
//   instruction_o/pc_o - FIFO head, valid when data_ready_o
//   data_ready_o       - head valid and consumed this cycle
// Optional (macro RV32IM_FETCH_PERF_EN): saturating 32-bit counters
//   perf_fetch_count_o, perf_flush_count_o, perf_discard_count_o.
module rv32im_fetch
  import rv32im_fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter int unsigned     PTR_BITS   = $clog2(FIFO_DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  rv32im_fetch_if.master  mem,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] instruction_o,
  output logic [XLEN-1:0] pc_o,
  output logic            data_ready_o
`ifdef RV32IM_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_count_o,
  output logic [31:0]     perf_flush_count_o,
  output logic [31:0]     perf_discard_count_o
`endif
);

  localparam int unsigned CNT_W = PTR_BITS + 1;

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              push, drop, pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count, cnt_after_pop;
  logic [2*XLEN-1:0] fifo_head;
  logic              idle_room, req_room;

  assign data_ready_o = ~fifo_empty & ~stall_i & ~redirect_i;
  assign pop          = data_ready_o;

  // Room is judged after this cycle's pop; REQ additionally accounts for
  // the word being written on this ack.
  assign cnt_after_pop = fifo_count - CNT_W'(pop);
  assign idle_room     = ~fifo_full | pop;
  assign req_room      = (cnt_after_pop + CNT_W'(1)) < CNT_W'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    drop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!redirect_i && idle_room) begin
          state_d = REQ;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (mem.mem_ack_i) begin
          if (redirect_i) begin
            state_d = IDLE;
            drop    = 1'b1;
          end else begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + XLEN'(ILEN_BYTES);
            if (req_room) begin
              state_d = REQ;
              addr_d  = fetch_pc_q + XLEN'(ILEN_BYTES);
            end else begin
              state_d = IDLE;
            end
          end
        end else if (redirect_i) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem.mem_ack_i) begin
          state_d = IDLE;
          drop    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_i) fetch_pc_d = redirect_pc_i & ~XLEN'(3);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  assign mem.mem_stb_o  = (state_q != IDLE);
  assign mem.mem_addr_o = addr_q;

  rv32im_fetch_fifo #(
    .WIDTH    (2 * XLEN),
    .DEPTH    (FIFO_DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (push),
    .wdata_i ({mem.mem_data_i, fetch_pc_q}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign instruction_o = fifo_head[2*XLEN-1:XLEN];
  assign pc_o          = fifo_head[XLEN-1:0];

`ifdef RV32IM_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_flush_q, perf_discard_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetch_q   <= '0;
      perf_flush_q   <= '0;
      perf_discard_q <= '0;
    end else begin
      if (push && perf_fetch_q != '1)       perf_fetch_q   <= perf_fetch_q + 32'd1;
      if (redirect_i && perf_flush_q != '1) perf_flush_q   <= perf_flush_q + 32'd1;
      if (drop && perf_discard_q != '1)     perf_discard_q <= perf_discard_q + 32'd1;
    end
  end

  assign perf_fetch_count_o   = perf_fetch_q;
  assign perf_flush_count_o   = perf_flush_q;
  assign perf_discard_count_o = perf_discard_q;
`endif

endmodule

// File: tb/tb_rv32im_fetch.sv
// tb_rv32im_fetch: self-checking bench for rv32im_fetch.
// A queue-based reference of the fetch stage is compared against the DUT on
// every negedge; directed scenarios add literal expectations on top.
// Optional counters (macro RV32IM_FETCH_PERF_EN) are connected when defined.
module tb_rv32im_fetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] rpc = '0;
  logic [31:0] instr, pc;
  logic        ready;

  rv32im_fetch_if #(.XLEN(32)) bus ();

`ifdef RV32IM_FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_flush, perf_discard;
`endif

  rv32im_fetch #(
    .XLEN       (32),
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mem           (bus.master),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (rpc),
    .instruction_o (instr),
    .pc_o          (pc),
    .data_ready_o  (ready)
`ifdef RV32IM_FETCH_PERF_EN
    ,
    .perf_fetch_count_o   (perf_fetch),
    .perf_flush_count_o   (perf_flush),
    .perf_discard_count_o (perf_discard)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- memory responder ----------------
  int unsigned ack_lat = 0;
  int unsigned wait_cnt = 0;
  bit          spur = 1'b0;
  bit          p_stb = 1'b0, p_ack = 1'b0;

  initial begin
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n)              wait_cnt = 0;
    else if (p_stb && p_ack) wait_cnt = 0;
    else if (p_stb)          wait_cnt++;
    if (!rst_n)              bus.mem_ack_i = 1'b0;
    else if (bus.mem_stb_o)  bus.mem_ack_i = (wait_cnt >= ack_lat);
    else                     bus.mem_ack_i = spur;
    bus.mem_data_i = (bus.mem_ack_i && bus.mem_stb_o) ? (bus.mem_addr_o ^ KEY) : 32'hDEAD_BEEF;
  end

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_fetch_pc = RPC, m_addr = RPC;
  bit          m_busy = 1'b0, m_drop = 1'b0;

  bit          s_stall, s_redir, s_ack;
  logic [31:0] s_rpc, s_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_fetch_pc = RPC;
      m_addr     = RPC;
      m_busy     = 1'b0;
      m_drop     = 1'b0;
    end else begin
      int unsigned n;
      bit          take, ack;
      n    = m_q.size();
      take = (n > 0) && !s_stall && !s_redir;
      ack  = m_busy && s_ack;
      if (s_redir)   m_q.delete();
      else if (take) void'(m_q.pop_front());
      if (!m_busy) begin
        if (!s_redir && (n - int'(take)) < DEPTH) begin
          m_busy = 1'b1;
          m_drop = 1'b0;
          m_addr = m_fetch_pc;
        end
      end else if (ack) begin
        if (!m_drop && !s_redir) begin
          m_q.push_back({s_data, m_addr});
          m_fetch_pc = m_addr + 32'd4;
          if (m_q.size() < DEPTH) m_addr = m_addr + 32'd4;
          else                    m_busy = 1'b0;
        end else begin
          m_busy = 1'b0;
        end
      end else if (s_redir) begin
        m_drop = 1'b1;
      end
      if (s_redir) m_fetch_pc = s_rpc & ~32'h3;
    end
  end

  // ---------------- compare + logging ----------------
  typedef struct { logic [31:0] pc; logic [31:0] instr; int c; } pres_t;
  pres_t       pres_q[$];
  logic [31:0] req_q[$];

  always @(negedge clk) begin
    s_stall = stall;
    s_redir = redirect;
    s_rpc   = rpc;
    s_ack   = bus.mem_ack_i;
    s_data  = bus.mem_data_i;
    if (rst_n) begin
      bit exp_rdy;
      exp_rdy = (m_q.size() > 0) && !stall && !redirect;
      chk("mem_stb_o", {31'b0, bus.mem_stb_o}, {31'b0, m_busy});
      if (m_busy) chk("mem_addr_o", bus.mem_addr_o, m_addr);
      chk("data_ready_o", {31'b0, ready}, {31'b0, exp_rdy});
      if (exp_rdy && ready) begin
        chk("pc_o", pc, m_q[0].pc);
        chk("instruction_o", instr, m_q[0].instr);
      end
      if (bus.mem_stb_o && (!p_stb || p_ack)) req_q.push_back(bus.mem_addr_o);
      if (ready) pres_q.push_back('{pc, instr, cyc});
      p_stb = bus.mem_stb_o;
      p_ack = bus.mem_ack_i;
    end else begin
      p_stb = 1'b0;
      p_ack = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    tick(2);
    chk("rst_stb", {31'b0, bus.mem_stb_o}, 32'd0);
    chk("rst_addr", bus.mem_addr_o, RPC);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    req_q.delete();
    pres_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_addr(input logic [31:0] a, output bit found);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1);
      if (bus.mem_stb_o && bus.mem_addr_o == a) found = 1'b1;
    end
  endtask

  initial begin
    bit found;

    // T1: streaming with same-cycle ack
    ack_lat = 0;
    stall   = 1'b0;
    do_reset();
    tick(12);
    chk("t1_first_req", req_q[0], 32'h0);
    for (int i = 0; i < 6; i++) begin
      chk("t1_pc", pres_q[i].pc, 32'(i * 4));
      chk("t1_instr", pres_q[i].instr, 32'(i * 4) ^ KEY);
      if (i > 0) chk("t1_nogap", 32'(pres_q[i].c - pres_q[i-1].c), 32'd1);
    end

    // T2: stall fills the FIFO, spurious ack ignored, then drain
    stall = 1'b1;
    do_reset();
    tick(8);
    spur = 1'b1;
    tick(2);
    spur = 1'b0;
    chk("t2_req_count", 32'(req_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_req_addr", req_q[i], 32'(i * 4));
    chk("t2_stb_low", {31'b0, bus.mem_stb_o}, 32'd0);
    pres_q.delete();
    stall = 1'b0;
    tick(5);
    for (int i = 0; i < 4; i++) begin
      chk("t2_pc", pres_q[i].pc, 32'(i * 4));
      if (i > 0) chk("t2_consec", 32'(pres_q[i].c - pres_q[i-1].c), 32'd1);
    end

    // T3: redirect during a 3-cycle-latency read of 0x8
    ack_lat = 3;
    do_reset();
    wait_addr(32'h8, found);
    chk("t3_found", {31'b0, found}, 32'd1);
    pres_q.delete();
    redirect = 1'b1;
    rpc      = 32'h100;
    tick(1);
    redirect = 1'b0;
    chk("t3_hold_stb", {31'b0, bus.mem_stb_o}, 32'd1);
    chk("t3_hold_addr", bus.mem_addr_o, 32'h8);
    tick(16);
    chk("t3_has_pres", {31'b0, pres_q.size() > 0}, 32'd1);
    if (pres_q.size() > 0) begin
      chk("t3_next_pc", pres_q[0].pc, 32'h100);
      chk("t3_next_instr", pres_q[0].instr, 32'h100 ^ KEY);
    end
    foreach (pres_q[i]) if (pres_q[i].pc == 32'h8) chk("t3_no_stale", pres_q[i].pc, 32'h100);

    // T4: redirect to 0x203 in the ack cycle
    ack_lat = 1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (bus.mem_ack_i && bus.mem_stb_o) found = 1'b1;
    end
    chk("t4_found", {31'b0, found}, 32'd1);
    req_q.delete();
    redirect = 1'b1;
    rpc      = 32'h203;
    tick(1);
    redirect = 1'b0;
    chk("t4_empty", {31'b0, ready}, 32'd0);
    tick(5);
    chk("t4_req_addr", req_q[0], 32'h200);

    // T5: steady push+pop at 3 entries across pointer wrap
    ack_lat = 0;
    stall   = 1'b1;
    do_reset();
    tick(10);
    stall = 1'b0;
    tick(3);
    pres_q.delete();
    for (int i = 0; i < 20; i++) begin
      chk("t5_count", 32'(dut.fifo_count), 32'd3);
      tick(1);
    end
    chk("t5_first_pc", pres_q[0].pc, 32'hC);
    for (int i = 1; i < 20; i++) begin
      chk("t5_seq_pc", pres_q[i].pc, pres_q[i-1].pc + 32'd4);
      chk("t5_consec", 32'(pres_q[i].c - pres_q[i-1].c), 32'd1);
    end

    // T6: asynchronous reset in the middle of a pending read
    ack_lat = 3;
    do_reset();
    wait_addr(32'h4, found);
    chk("t6_found", {31'b0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_stb", {31'b0, bus.mem_stb_o}, 32'd0);
    chk("t6_ready", {31'b0, ready}, 32'd0);
    chk("t6_addr", bus.mem_addr_o, RPC);
    tick(2);
    req_q.delete();
    rst_n = 1'b1;
    tick(6);
    chk("t6_first_req", req_q[0], RPC);

`ifdef RV32IM_FETCH_PERF_EN
    chk("perf_fetch_nz", {31'b0, perf_fetch != 0}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
